// File: rtl/esm_dep_scoreboard.sv
// Dependency scoreboard: tracks in-flight instructions per slot and
// flags which slots are free of RAW/WAW (optionally WAR) hazards.
module esm_dep_scoreboard #(
  parameter  int INSTR_W = 32,
  parameter  int BS      = 16,
  parameter  int REGNUM  = 32,
  parameter  int WAR_EN  = 0,
  localparam int IW      = $clog2(BS),
  localparam int RW      = $clog2(REGNUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ins_valid,
  output logic               ins_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               reg_write,
  input  logic               alu_src,
  output logic [IW-1:0]      alloc_index,
  input  logic               issue_valid,
  input  logic [IW-1:0]      issue_index,
  input  logic               complete_valid,
  input  logic [IW-1:0]      complete_index,
  input  logic               flush,
  output logic [BS-1:0]      independent_instr,
  output logic [IW:0]        occupancy
);

  logic [BS-1:0] valid_q;
  logic [BS-1:0] issued_q;
  logic [RW-1:0] rd_q  [BS];
  logic [RW-1:0] rs1_q [BS];
  logic [RW-1:0] rs2_q [BS];
  logic [BS-1:0] dep_q [BS];
  logic [IW:0]   occ_q;

  logic [RW-1:0] rd_d, rs1_d, rs2_d;
  logic [BS-1:0] new_dep;
  logic          accept, comp_ok, iss_ok;
  logic          unused_instr;

  assign unused_instr = ^instr_in;

  assign rd_d  = reg_write ? instr_in[7 +: RW] : '0;
  assign rs1_d = instr_in[15 +: RW];
  assign rs2_d = alu_src ? '0 : instr_in[20 +: RW];

  always_comb begin
    for (int i = 0; i < BS; i++) begin
      independent_instr[i] = valid_q[i] & ~issued_q[i] & ~|dep_q[i];
    end
  end

  always_comb begin
    logic found;
    found       = 1'b0;
    alloc_index = '0;
    for (int i = 0; i < BS; i++) begin
      if (!valid_q[i] && !found) begin
        alloc_index = IW'(i);
        found       = 1'b1;
      end
    end
  end

  assign occupancy = occ_q;
  assign ins_ready = (occ_q < (IW+1)'(BS)) & ~flush;
  assign accept    = ins_valid & ins_ready;
  assign comp_ok   = complete_valid & valid_q[complete_index];
  assign iss_ok    = issue_valid & independent_instr[issue_index];

  // A slot retiring this very edge is excluded from the new row.
  always_comb begin
    logic raw, waw, war;
    new_dep = '0;
    raw     = 1'b0;
    waw     = 1'b0;
    war     = 1'b0;
    for (int j = 0; j < BS; j++) begin
      raw = (rs1_d != '0 && rs1_d == rd_q[j]) ||
            (rs2_d != '0 && rs2_d == rd_q[j]);
      waw = (rd_d != '0 && rd_d == rd_q[j]);
      war = (WAR_EN != 0) && (rd_d != '0) &&
            (rd_d == rs1_q[j] || rd_d == rs2_q[j]);
      if (valid_q[j] &&
          !(comp_ok && complete_index == IW'(j))) begin
        new_dep[j] = raw | waw | war;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= '0;
      issued_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < BS; i++) begin
        rd_q[i]  <= '0;
        rs1_q[i] <= '0;
        rs2_q[i] <= '0;
        dep_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q  <= '0;
      issued_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < BS; i++) begin
        dep_q[i] <= '0;
      end
    end else begin
      if (iss_ok) begin
        issued_q[issue_index] <= 1'b1;
      end
      // Completion follows issue so it wins on the same slot.
      if (comp_ok) begin
        valid_q[complete_index]  <= 1'b0;
        issued_q[complete_index] <= 1'b0;
        for (int i = 0; i < BS; i++) begin
          dep_q[i][complete_index] <= 1'b0;
        end
        dep_q[complete_index] <= '0;
      end
      if (accept) begin
        valid_q[alloc_index]  <= 1'b1;
        issued_q[alloc_index] <= 1'b0;
        rd_q[alloc_index]     <= rd_d;
        rs1_q[alloc_index]    <= rs1_d;
        rs2_q[alloc_index]    <= rs2_d;
        dep_q[alloc_index]    <= new_dep;
      end
      occ_q <= occ_q + (IW+1)'(accept) - (IW+1)'(comp_ok);
    end
  end

endmodule

// File: tb/tb_esm_dep_scoreboard.sv
// Directed bench for esm_dep_scoreboard; two instances
// (WAR_EN=0 / WAR_EN=1) share one stimulus stream.
module tb_esm_dep_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ins_valid = 1'b0;
  logic [31:0] instr_in = '0;
  logic        reg_write = 1'b0;
  logic        alu_src = 1'b0;
  logic        issue_valid = 1'b0;
  logic [3:0]  issue_index = '0;
  logic        complete_valid = 1'b0;
  logic [3:0]  complete_index = '0;
  logic        flush = 1'b0;

  logic        rdy0, rdy1;
  logic [3:0]  al0, al1;
  logic [15:0] ind0, ind1;
  logic [4:0]  occ0, occ1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  esm_dep_scoreboard #(.WAR_EN(0)) dut0 (
    .clk(clk), .rst(rst),
    .ins_valid(ins_valid), .ins_ready(rdy0),
    .instr_in(instr_in), .reg_write(reg_write),
    .alu_src(alu_src), .alloc_index(al0),
    .issue_valid(issue_valid), .issue_index(issue_index),
    .complete_valid(complete_valid),
    .complete_index(complete_index),
    .flush(flush), .independent_instr(ind0),
    .occupancy(occ0)
  );

  esm_dep_scoreboard #(.WAR_EN(1)) dut1 (
    .clk(clk), .rst(rst),
    .ins_valid(ins_valid), .ins_ready(rdy1),
    .instr_in(instr_in), .reg_write(reg_write),
    .alu_src(alu_src), .alloc_index(al1),
    .issue_valid(issue_valid), .issue_index(issue_index),
    .complete_valid(complete_valid),
    .complete_index(complete_index),
    .flush(flush), .independent_instr(ind1),
    .occupancy(occ1)
  );

  typedef struct {
    bit          iv;
    logic [4:0]  rd, rs1, rs2;
    bit          rw, as;
    bit          isv;
    logic [3:0]  isi;
    bit          cv;
    logic [3:0]  ci;
    bit          fl;
    logic [15:0] e_ind;
    logic [4:0]  e_occ;
    logic [3:0]  e_al;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(
    bit iv, int rd, int rs1, int rs2, bit rw, bit as,
    bit isv, int isi, bit cv, int ci, bit fl,
    int ind, int occ, int al);
    vec_t t;
    t.iv = iv; t.rd = 5'(rd); t.rs1 = 5'(rs1); t.rs2 = 5'(rs2);
    t.rw = rw; t.as = as; t.isv = isv; t.isi = 4'(isi);
    t.cv = cv; t.ci = 4'(ci); t.fl = fl;
    t.e_ind = 16'(ind); t.e_occ = 5'(occ); t.e_al = 4'(al);
    return t;
  endfunction

  function automatic logic [31:0] mk(int rd, int rs1, int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    ins_valid = 0; reg_write = 0; alu_src = 0; instr_in = '0;
    issue_valid = 0; issue_index = '0;
    complete_valid = 0; complete_index = '0; flush = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1 idle();
    #1;
  endtask

  task automatic ins(int rd, int rs1, int rs2, bit rw, bit as);
    ins_valid = 1; instr_in = mk(rd, rs1, rs2);
    reg_write = rw; alu_src = as;
  endtask

  task automatic state(string nm, logic [15:0] ind, logic [4:0] occ,
                       logic rdy, logic [3:0] al);
    chk({nm, ".ind0"}, 32'(ind0), 32'(ind));
    chk({nm, ".occ0"}, 32'(occ0), 32'(occ));
    chk({nm, ".rdy0"}, 32'(rdy0), 32'(rdy));
    chk({nm, ".al0"},  32'(al0),  32'(al));
  endtask

  initial begin
    // iv rd rs1 rs2 rw as isv isi cv ci fl ind occ al
    tbl.push_back(V(1,1,2,3,1,0, 0,0,0,0,0, 'h1,1,1));
    tbl.push_back(V(1,4,1,5,1,0, 0,0,0,0,0, 'h1,2,2));
    tbl.push_back(V(0,0,0,0,0,0, 0,0,1,0,0, 'h2,1,0));
    tbl.push_back(V(0,0,0,0,0,0, 1,1,0,0,0, 'h0,1,0));
    tbl.push_back(V(1,6,1,0,1,0, 0,0,0,0,0, 'h1,2,2));
    tbl.push_back(V(0,0,0,0,0,0, 1,1,1,1,0, 'h1,1,1));
    tbl.push_back(V(1,7,6,8,1,0, 0,0,1,0,0, 'h2,1,0));
    tbl.push_back(V(1,7,0,9,0,1, 0,0,0,0,0, 'h3,2,2));
    tbl.push_back(V(1,9,0,7,1,1, 0,0,0,0,0, 'h7,3,3));
    tbl.push_back(V(1,0,9,0,1,0, 0,0,0,0,0, 'h7,4,4));
    tbl.push_back(V(0,0,0,0,0,0, 1,3,0,0,0, 'h7,4,4));
    tbl.push_back(V(0,0,0,0,0,0, 1,2,0,0,0, 'h3,4,4));
    tbl.push_back(V(0,0,0,0,0,0, 0,0,1,5,0, 'h3,4,4));
    tbl.push_back(V(0,0,0,0,0,0, 0,0,1,2,0, 'hB,3,2));
    tbl.push_back(V(0,0,0,0,0,0, 1,3,1,3,0, 'h3,2,2));
    tbl.push_back(V(1,3,0,0,1,0, 1,0,1,1,1, 'h0,0,0));
    tbl.push_back(V(1,6,0,0,1,0, 0,0,0,0,0, 'h1,1,1));
    tbl.push_back(V(1,6,0,0,1,0, 0,0,0,0,0, 'h1,2,2));
    tbl.push_back(V(0,0,0,0,0,0, 1,0,0,0,0, 'h0,2,2));
    tbl.push_back(V(0,0,0,0,0,0, 0,0,0,0,1, 'h0,0,0));

    idle();
    #12;
    state("reset_low", 16'h0, 5'd0, 1'b1, 4'd0);
    rst = 1'b1;
    @(negedge clk);
    state("reset", 16'h0, 5'd0, 1'b1, 4'd0);

    foreach (tbl[k]) begin
      vec_t t;
      string nm;
      t = tbl[k];
      nm = $sformatf("vec%0d", k);
      ins_valid = t.iv; instr_in = mk(t.rd, t.rs1, t.rs2);
      reg_write = t.rw; alu_src = t.as;
      issue_valid = t.isv; issue_index = t.isi;
      complete_valid = t.cv; complete_index = t.ci;
      flush = t.fl;
      step();
      state(nm, t.e_ind, t.e_occ, 1'b1, t.e_al);
      chk({nm, ".ind1"}, 32'(ind1), 32'(t.e_ind));
      chk({nm, ".occ1"}, 32'(occ1), 32'(t.e_occ));
    end

    // WAR: read x7 then write x7
    ins(0, 7, 0, 0, 0); step();
    ins(7, 0, 0, 1, 0); step();
    chk("war_off.ind", 32'(ind0), 32'h3);
    chk("war_on.ind",  32'(ind1), 32'h1);
    flush = 1; #1;
    chk("flush_ready", 32'(rdy0), 32'h0);
    step();

    // Fill all 16 slots with independent writers
    for (int i = 0; i < 16; i++) begin
      ins(i + 1, 0, 0, 1, 0);
      step();
    end
    state("full", 16'hFFFF, 5'd16, 1'b0, 4'd0);
    ins(20, 0, 0, 1, 0); step();
    chk("full_drop.occ", 32'(occ0), 32'd16);
    complete_valid = 1; complete_index = 4'd5; step();
    state("free5", 16'hFFDF, 5'd15, 1'b1, 4'd5);
    flush = 1; step();
    state("flush15", 16'h0, 5'd0, 1'b1, 4'd0);

    // Flush with 8 entries
    for (int i = 0; i < 8; i++) begin
      ins(i + 1, 0, 0, 1, 0);
      step();
    end
    chk("eight.occ", 32'(occ0), 32'd8);
    flush = 1; step();
    state("flush8", 16'h0, 5'd0, 1'b1, 4'd0);

    // Reset asserted mid-insert
    for (int i = 0; i < 3; i++) begin
      ins(i + 1, 0, 0, 1, 0);
      step();
    end
    chk("pre_rst.occ", 32'(occ0), 32'd3);
    ins(9, 0, 0, 1, 0);
    issue_valid = 1; issue_index = 4'd0;
    complete_valid = 1; complete_index = 4'd1;
    #2 rst = 1'b0;
    #1;
    chk("rst_async.occ", 32'(occ0), 32'd0);
    chk("rst_async.ind", 32'(ind0), 32'd0);
    chk("rst_async.occ1", 32'(occ1), 32'd0);
    @(posedge clk);
    #1 idle();
    #2 rst = 1'b1;
    #1;
    state("rst_rel", 16'h0, 5'd0, 1'b1, 4'd0);
    step();
    state("rst_idle", 16'h0, 5'd0, 1'b1, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/esm_dep_scoreboard.md
ESM_DEP_SCOREBOARD -- requirements
Module: esm_dep_scoreboard

Interface
REQ-001 Parameter: INSTR_W, 32, instruction word width.
REQ-002 Parameter: BS, 16, buffer slots (power of two, >=2); IW = $clog2(BS).
REQ-003 Parameter: REGNUM, 32, architectural registers; RW = $clog2(REGNUM).
REQ-004 Parameter: WAR_EN, 0, 1 = also record write-after-read hazards.
REQ-005 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-006 Port: rst  in  1  asynchronous, active-low reset.
REQ-007 Port: ins_valid  in  1  insert request.
REQ-008 Port: ins_ready  out  1  slot free and no flush; insert accepted when ins_valid & ins_ready.
REQ-009 Port: instr_in  in  INSTR_W  instruction; rd=[11:7], rs1=[19:15], rs2=[24:20].
REQ-010 Port: reg_write  in  1  instruction writes rd.
REQ-011 Port: alu_src  in  1  1 = rs2 not read.
REQ-012 Port: alloc_index  out  IW  slot the current insert will occupy.
REQ-013 Port: issue_valid / issue_index  in  1 / IW  slot issued this cycle.
REQ-014 Port: complete_valid / complete_index  in  1 / IW  slot retired this cycle.
REQ-015 Port: flush  in  1  discard all entries.
REQ-016 Port: independent_instr  out  BS (bit 0 = slot 0)  slot valid, not issued, no outstanding dependency.
REQ-017 Port: occupancy  out  IW+1  number of valid slots.

Function
REQ-018 Per slot state: valid, issued, rd, rs1, rs2, dependency row dep[i][0:BS-1].
REQ-019 Decode: rd forced 0 when reg_write=0; rs2 forced 0 when alu_src=1; register 0 never creates a dependency.
REQ-020 alloc_index = lowest-numbered slot with valid=0; ins_ready = (occupancy<BS) & ~flush.
REQ-021 On accepted insert into slot n: valid[n]<=1, issued[n]<=0, fields stored, dep[n][j]<=1 for every valid slot j where RAW (rs1 or rs2 == rd[j]) or WAW (rd == rd[j]), or, when WAR_EN=1, WAR (rd == rs1[j] or rs2[j]).
REQ-022 Dependency computed only against slots valid before the edge; dep[n][n] always 0.
REQ-023 independent_instr[i] = valid[i] & ~issued[i] & ~|dep[i], driven from registered state; new entry visible one edge after acceptance.
REQ-024 Issue: issued[k]<=1 only if independent_instr[k]=1; otherwise ignored; issued slot keeps blocking dependents until completion.
REQ-025 Completion of slot c with valid[c]=1: valid[c]<=0, issued[c]<=0, column dep[*][c]<=0; completion of invalid slot ignored.
REQ-026 Simultaneous insert and completion of c: c excluded from the new row's dependency check and its column cleared; freed slot c not reused until next cycle.
REQ-027 Simultaneous issue and completion of the same slot: completion wins.
REQ-028 Flush: all valid, issued, dep cleared at the edge; any insert/issue/completion that cycle dropped.
REQ-029 occupancy = popcount(valid), registered; updated same edge as valid.

Reset
REQ-030 rst low: immediately clear valid, issued, dep, fields; independent_instr=0, occupancy=0, alloc_index=0, ins_ready=1 once rst high (flush low).
REQ-031 Reset mid-operation discards all entries; no pending issue/complete effect survives.

Verification
REQ-032 Insert x1=x2+x3 (reg_write=1) then x4=x1+x5 -> slots 0,1; after 2nd edge independent_instr[0]=1, [1]=0; complete 0 -> next cycle [1]=1.
REQ-033 WAW: two writes to x6 in slots 0,1 -> dep[1][0]=1; WAR_EN=1 read x7 in slot 0 then write x7 -> slot 1 blocked; WAR_EN=0 -> slot 1 independent.
REQ-034 Fill BS=16 independent entries -> occupancy=16, ins_ready=0, insert ignored; complete slot 5 -> alloc_index=5 next cycle.
REQ-035 Insert depending on slot 2 in same cycle slot 2 completes -> new entry independent at next edge.
REQ-036 Issue dependent slot -> ignored; issue independent slot 0 -> independent_instr[0]=0 next cycle, dependents still blocked until complete.
REQ-037 Flush with 8 entries, and rst low mid-insert -> occupancy=0, independent_instr=0, ins_ready=1 after release.
